// File: rtl/gf180mcu_fd_sc_mcu7t5v0__muxn_pkg.sv
// Shared types and helpers for the synchronous break-before-make N:1 mux.
package gf180mcu_fd_sc_mcu7t5v0__muxn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_COMMIT = 2'd2
    } muxn_state_e;

    // Guard counter width; covers GUARD values 0..15.
    localparam int unsigned CNT_W = 4;

    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__muxn_core.sv
// Combinational NUM_IN:1 selector of WIDTH-bit channels packed into one bus.
module gf180mcu_fd_sc_mcu7t5v0__muxn_core #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 4,
    parameter int SELW   = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        dout
);

    // Out-of-range selects yield zero rather than an undefined slice.
    always_comb begin
        dout = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SELW'(k)) begin
                dout = din[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__muxn_sync.sv
// Registered N:1 mux with handshaked channel switching and a break-before-make
// guard interval during which Z either holds or is forced to zero.
module gf180mcu_fd_sc_mcu7t5v0__muxn_sync
    import gf180mcu_fd_sc_mcu7t5v0__muxn_pkg::*;
#(
    parameter  int WIDTH     = 1,
    parameter  int NUM_IN    = 4,
    parameter  int GUARD     = 2,
    parameter  int HOLD_MODE = 0,
    localparam int SELW      = sel_width(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] I,
    input  logic [SELW-1:0]         SEL_REQ,
    input  logic                    SEL_VLD,
    output logic                    SEL_RDY,
    output logic [WIDTH-1:0]        Z,
    output logic [SELW-1:0]         SEL_CUR,
    output logic                    SWITCHING,
    output logic                    ERR
);

    muxn_state_e      state_q, state_d;
    logic [SELW-1:0]  sel_cur_q, sel_cur_d;
    logic [SELW-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] z_switch;
    logic             accept;
    logic             req_bad;

    gf180mcu_fd_sc_mcu7t5v0__muxn_core #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SELW   (SELW)
    ) u_core (
        .din  (I),
        .sel  (sel_cur_q),
        .dout (mux_out)
    );

    assign SEL_RDY   = (state_q == ST_IDLE) && !RST;
    assign SWITCHING = (state_q != ST_IDLE);
    assign SEL_CUR   = sel_cur_q;
    assign Z         = z_q;
    assign ERR       = err_q;

    assign accept   = SEL_VLD && (state_q == ST_IDLE);
    assign req_bad  = int'(SEL_REQ) >= NUM_IN;
    assign z_switch = (HOLD_MODE != 0) ? '0 : z_q;

    always_comb begin
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                z_d = mux_out;
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (SEL_REQ != sel_cur_q) begin
                        pend_d = SEL_REQ;
                        if (GUARD == 0) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_GUARD;
                            cnt_d   = CNT_W'(GUARD - 1);
                        end
                    end
                end
            end
            ST_GUARD: begin
                z_d = z_switch;
                if (cnt_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_COMMIT: begin
                z_d       = z_switch;
                sel_cur_d = pend_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sel_cur_q <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            z_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_cur_q <= sel_cur_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__muxn_sync.sv
// Directed bench: four mux instances (hold, zero-fill, 3-channel, no-guard)
// sharing clock, reset and data; Z expectations flow through a scoreboard.
module tb_gf180mcu_fd_sc_mcu7t5v0__muxn_sync;

    localparam int unsigned A = 0;  // GUARD=2, HOLD_MODE=0
    localparam int unsigned B = 1;  // GUARD=2, HOLD_MODE=1
    localparam int unsigned C = 2;  // NUM_IN=3
    localparam int unsigned D = 3;  // GUARD=0

    typedef struct {
        int unsigned inst;
        logic [7:0]  z;
        string       tag;
    } zexp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] i_bus;
    logic [1:0]  req [4];
    logic        vld [4];
    logic        rdy [4];
    logic [7:0]  z   [4];
    logic [1:0]  cur [4];
    logic        sw  [4];
    logic        err [4];

    zexp_t sb[$];
    int    total = 0;
    int    bad   = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__muxn_sync #(.WIDTH(8), .NUM_IN(4), .GUARD(2), .HOLD_MODE(0)) u_a (
        .CLK(CLK), .RST(RST), .I(i_bus), .SEL_REQ(req[A]), .SEL_VLD(vld[A]), .SEL_RDY(rdy[A]),
        .Z(z[A]), .SEL_CUR(cur[A]), .SWITCHING(sw[A]), .ERR(err[A]));

    gf180mcu_fd_sc_mcu7t5v0__muxn_sync #(.WIDTH(8), .NUM_IN(4), .GUARD(2), .HOLD_MODE(1)) u_b (
        .CLK(CLK), .RST(RST), .I(i_bus), .SEL_REQ(req[B]), .SEL_VLD(vld[B]), .SEL_RDY(rdy[B]),
        .Z(z[B]), .SEL_CUR(cur[B]), .SWITCHING(sw[B]), .ERR(err[B]));

    gf180mcu_fd_sc_mcu7t5v0__muxn_sync #(.WIDTH(8), .NUM_IN(3), .GUARD(2), .HOLD_MODE(0)) u_c (
        .CLK(CLK), .RST(RST), .I(i_bus[23:0]), .SEL_REQ(req[C]), .SEL_VLD(vld[C]), .SEL_RDY(rdy[C]),
        .Z(z[C]), .SEL_CUR(cur[C]), .SWITCHING(sw[C]), .ERR(err[C]));

    gf180mcu_fd_sc_mcu7t5v0__muxn_sync #(.WIDTH(8), .NUM_IN(4), .GUARD(0), .HOLD_MODE(0)) u_d (
        .CLK(CLK), .RST(RST), .I(i_bus), .SEL_REQ(req[D]), .SEL_VLD(vld[D]), .SEL_RDY(rdy[D]),
        .Z(z[D]), .SEL_CUR(cur[D]), .SWITCHING(sw[D]), .ERR(err[D]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_z(input int unsigned inst, input logic [7:0] v, input string tag);
        zexp_t e;
        e.inst = inst;
        e.z    = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1 time unit later and retire all pending Z expectations.
    task automatic tick();
        zexp_t e;
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, z[e.inst], e.z);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b1;
        i_bus = {8'hC3, 8'h3C, 8'h5A, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            req[i] = 2'd0;
            vld[i] = 1'b0;
        end
        tick();
        tick();

        // Reset state
        chk("rst_z_a",    z[A],         8'h00);
        chk("rst_cur_a",  8'(cur[A]),   8'h00);
        chk("rst_rdy_a",  8'(rdy[A]),   8'h00);
        chk("rst_sw_a",   8'(sw[A]),    8'h00);
        chk("rst_err_a",  8'(err[A]),   8'h00);
        chk("rst_cur_d",  8'(cur[D]),   8'h00);

        RST = 1'b0;
        #1;
        chk("rdy_after_rst_a", 8'(rdy[A]), 8'h01);
        push_z(A, 8'hA5, "z_ch0_a");
        push_z(B, 8'hA5, "z_ch0_b");
        tick();
        chk("cur_ch0_a", 8'(cur[A]), 8'h00);
        chk("rdy_idle_a", 8'(rdy[A]), 8'h01);

        // Switch to channel 2 on A (hold) and B (zero-fill)
        req[A] = 2'd2; vld[A] = 1'b1;
        req[B] = 2'd2; vld[B] = 1'b1;
        push_z(A, 8'hA5, "z_e0_a");
        push_z(B, 8'hA5, "z_e0_b");
        tick();
        vld[A] = 1'b0;
        vld[B] = 1'b0;
        i_bus[7:0] = 8'h11;
        chk("rdy_e0_a", 8'(rdy[A]), 8'h00);
        chk("sw_e0_a",  8'(sw[A]),  8'h01);
        chk("rdy_e0_b", 8'(rdy[B]), 8'h00);
        for (int n = 1; n <= 2; n++) begin
            push_z(A, 8'hA5, "z_guard_hold_a");
            push_z(B, 8'h00, "z_guard_zero_b");
            tick();
            chk("rdy_guard_a", 8'(rdy[A]), 8'h00);
            chk("sw_guard_a",  8'(sw[A]),  8'h01);
            chk("cur_guard_a", 8'(cur[A]), 8'h00);
        end
        push_z(A, 8'hA5, "z_e3_a");
        push_z(B, 8'h00, "z_e3_b");
        tick();
        chk("rdy_e3_a", 8'(rdy[A]), 8'h01);
        chk("sw_e3_a",  8'(sw[A]),  8'h00);
        chk("cur_e3_a", 8'(cur[A]), 8'h02);
        chk("cur_e3_b", 8'(cur[B]), 8'h02);
        push_z(A, 8'h3C, "z_e4_a");
        push_z(B, 8'h3C, "z_e4_b");
        tick();

        // Out-of-range and same-channel requests on the 3-channel instance
        req[C] = 2'd3; vld[C] = 1'b1;
        tick();
        vld[C] = 1'b0;
        chk("err_pulse_c", 8'(err[C]), 8'h01);
        chk("err_cur_c",   8'(cur[C]), 8'h00);
        chk("err_rdy_c",   8'(rdy[C]), 8'h01);
        chk("err_sw_c",    8'(sw[C]),  8'h00);
        tick();
        chk("err_clear_c", 8'(err[C]), 8'h00);
        req[C] = 2'd0; vld[C] = 1'b1;
        tick();
        vld[C] = 1'b0;
        chk("same_sw_c",  8'(sw[C]),  8'h00);
        chk("same_rdy_c", 8'(rdy[C]), 8'h01);
        chk("same_err_c", 8'(err[C]), 8'h00);

        // Reset while in GUARD: the pending channel 1 must never commit
        req[A] = 2'd1; vld[A] = 1'b1;
        tick();
        vld[A] = 1'b0;
        chk("rg_sw_e0_a", 8'(sw[A]), 8'h01);
        tick();
        chk("rg_sw_e1_a", 8'(sw[A]), 8'h01);
        RST = 1'b1;
        push_z(A, 8'h00, "rg_z_rst_a");
        tick();
        chk("rg_sw_rst_a",  8'(sw[A]),  8'h00);
        chk("rg_cur_rst_a", 8'(cur[A]), 8'h00);
        RST = 1'b0;
        push_z(A, 8'h11, "rg_z_resume_a");
        tick();
        tick();
        tick();
        chk("rg_cur_later_a", 8'(cur[A]), 8'h00);
        chk("rg_sw_later_a",  8'(sw[A]),  8'h00);

        // GUARD=0, back-to-back requests 1 then 3 with SEL_VLD held
        chk("d_rdy_pre", 8'(rdy[D]), 8'h01);
        req[D] = 2'd1; vld[D] = 1'b1;
        tick();
        chk("d_rdy_e0", 8'(rdy[D]), 8'h00);
        chk("d_sw_e0",  8'(sw[D]),  8'h01);
        chk("d_cur_e0", 8'(cur[D]), 8'h00);
        req[D] = 2'd3;
        tick();
        chk("d_rdy_e1", 8'(rdy[D]), 8'h01);
        chk("d_cur_e1", 8'(cur[D]), 8'h01);
        push_z(D, 8'h5A, "d_z_e2");
        tick();
        vld[D] = 1'b0;
        chk("d_rdy_e2", 8'(rdy[D]), 8'h00);
        chk("d_cur_e2", 8'(cur[D]), 8'h01);
        tick();
        chk("d_rdy_e3", 8'(rdy[D]), 8'h01);
        chk("d_cur_e3", 8'(cur[D]), 8'h03);
        push_z(D, 8'hC3, "d_z_e4");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
